hdmi_framer: RTL and testbench
==============================

// Module: hdmi_framer
// PURPOSE
//  Parametrised HDMI raster/framer: generates H/V timing, pixel read strobes
//  and the per-cycle HDMI period stream (control, preambles, guard bands,
//  video, data islands) for three downstream tmdsencode channel encoders.
//  Adds BPC generalisation and one host-supplied 32-cycle data-island packet
//  per line in horizontal blanking; sits between the pixel source and TMDS.
// PARAMETERS
//  HW   12  width of horizontal mode inputs and hpos counter
//  VW   12  width of vertical mode inputs and vpos counter
//  BPC   8  bits per colour on i_rgb_pix (3*BPC total); top 8 bits used
// PORTS
//  i_pixclk       in   1      pixel clock; all logic on rising edge
//  i_reset        in   1      synchronous, active-high reset
//  i_rgb_pix      in   3*BPC  {red,grn,blu}, sampled when o_rd high
//  i_hm_width/porch/synch/raw  in HW  active, sync start, sync end, total
//  i_vm_height/porch/synch/raw in VW  same, in lines
//  i_pkt_valid    in   1      packet word available
//  i_pkt_word     in   9      {hdr_bit, ch2_nibble[3:0], ch1_nibble[3:0]}
//  o_pkt_ready    out  1      word consumed this cycle
//  o_pkt_underflow out 1      pulse: i_pkt_valid low during island DATA
//  o_rd/o_newline/o_newframe out 1  pixel strobe, line/frame markers
//  o_type         out  2      00 GUARD, 01 CTL, 10 DATA_ISLAND, 11 VIDEO
//  o_ctl          out  4      {CTL3..CTL0} for channels 2/1
//  o_data         out  12     {ch2[3:0], ch1[3:0], ch0[3:0]} island nibbles
//  o_red/o_grn/o_blu out 8    pixel value, zero outside VIDEO
// BEHAVIOUR
//  - Mode inputs stable outside reset; width<porch<synch<raw, same for V;
//    raw-width >= 60. Otherwise behaviour undefined.
//  - hpos 0..raw-1 wraps; vpos increments (wraps at vm_raw-1) when
//    hpos==porch-1. hsync=1 for porch<=hpos<synch; vsync=1 for
//    vm_porch<=vpos<vm_synch. Outputs are registered: values at t+1 describe
//    counters at t. o_data[1:0]={vsync,hsync} at all times.
//  - o_rd at t => i_rgb_pix sampled at t, shown on o_red.. at t+1 with
//    o_type=VIDEO. o_rd only for hpos<width, vpos<height, first frame done.
//  - o_newline 1-cycle pulse per line; o_newframe coincides with o_newline
//    on last active line. First frame after reset: timing runs, o_rd=0.
//  - Video preamble (next line active): hpos raw-10..raw-3 -> CTL,
//    o_ctl=4'h1; raw-2,raw-1 -> GUARD; hpos 0 -> VIDEO. Else CTL, o_ctl=0.
//  - Island FSM: IDLE->PRE(8)->LGUARD(2)->DATA(32)->TGUARD(2)->IDLE.
//    Committed iff i_pkt_valid at hpos==width+3 (any line, incl. V-blank);
//    PRE starts at width+4: CTL, o_ctl=4'h5; guards o_type=GUARD.
//  - DATA: o_pkt_ready=1 each of 32 cycles; ch0={~first,hdr_bit,vs,hs},
//    ch1/ch2 from i_pkt_word. i_pkt_valid low: zeros sent, underflow pulses,
//    count continues (no stretch). Island and video preamble never overlap.
//  - Reset: hpos=vpos=0, o_type=GUARD, o_ctl=0, all 1-bit outputs 0, pixels
//    0, FSM IDLE; mid-island reset aborts, o_pkt_ready low next cycle.
// CONFIGURATION
//  HDMI_FRAMER_ISLAND_EN defined: island FSM and packet port active.
//  Undefined: no FSM; o_pkt_ready=0, o_pkt_underflow=0, never DATA_ISLAND,
//  o_ctl never 4'h5, o_data[11:2]=0 (DVI-compatible stream).
// TESTING
//  1 Mode 16/20/24/32 x 17/19/21/23, no pkt -> period 32x23 cycles, o_rd 16
//    per active line from frame 2, o_newframe once per 736 cycles.
//  2 Active line end -> CTL ctl=1 at hpos 22..29, GUARD at 30,31, VIDEO at 0;
//    after last active line no preamble and no VIDEO.
//  3 ISLAND_EN, raw=80, i_pkt_valid held -> CTL ctl=5 at 20..27, GUARD
//    28,29, 32 DATA_ISLAND with ready, GUARD 62,63; ch0 bit3=0 only first.
//  4 Drop i_pkt_valid on DATA cycle 10 -> zero nibbles, underflow pulses each
//    invalid cycle, TGUARD still on schedule.
//  5 Reset during DATA cycle 5 -> next cycle GUARD, ready=0, hpos=vpos=0.
//  6 Macro undefined, same stim as 3 -> no DATA_ISLAND, ready always 0.

Source files
------------

// File: rtl/hdmi_framer.sv
// hdmi_framer: HDMI raster generator and period framer.
// Produces H/V timing, pixel read strobes and the per-cycle period stream
// (control, preambles, guard bands, video, data islands) for three
// downstream TMDS channel encoders.
// Optional feature macro: HDMI_FRAMER_ISLAND_EN enables the per-line
// data-island FSM and packet port; without it the stream is DVI-compatible.
module hdmi_framer #(
  parameter int HW  = 12,
  parameter int VW  = 12,
  parameter int BPC = 8
) (
  input  logic             i_pixclk,
  input  logic             i_reset,
  input  logic [3*BPC-1:0] i_rgb_pix,
  input  logic [HW-1:0]    i_hm_width,
  input  logic [HW-1:0]    i_hm_porch,
  input  logic [HW-1:0]    i_hm_synch,
  input  logic [HW-1:0]    i_hm_raw,
  input  logic [VW-1:0]    i_vm_height,
  input  logic [VW-1:0]    i_vm_porch,
  input  logic [VW-1:0]    i_vm_synch,
  input  logic [VW-1:0]    i_vm_raw,
  input  logic             i_pkt_valid,
  input  logic [8:0]       i_pkt_word,
  output logic             o_pkt_ready,
  output logic             o_pkt_underflow,
  output logic             o_rd,
  output logic             o_newline,
  output logic             o_newframe,
  output logic [1:0]       o_type,
  output logic [3:0]       o_ctl,
  output logic [11:0]      o_data,
  output logic [7:0]       o_red,
  output logic [7:0]       o_grn,
  output logic [7:0]       o_blu
);

  typedef enum logic [1:0] {
    T_GUARD  = 2'b00,
    T_CTL    = 2'b01,
    T_ISLAND = 2'b10,
    T_VIDEO  = 2'b11
  } period_t;

  logic [HW-1:0] hpos, hpos_nx;
  logic [VW-1:0] vpos, vpos_nx, vpos_inc, vline_nx;
  logic          hsync, vsync;
  logic          line_end, frame_end;
  logic          frame_done, done_nx;
  logic          rd_nx;
  logic          pre_ok, pre_window, pre_guard;

  logic          isl_pre, isl_guard, isl_data, isl_first, ready_nx;

  period_t       type_nx;
  logic [3:0]    ctl_nx;
  logic [11:0]   data_nx;
  logic [23:0]   pix_nx;
  logic          uf_nx;
  logic [8:0]    word;

  // Raster counters, sync decode, read lookahead and video preamble window.
  // vpos steps at the start of hsync, so the line whose active region comes
  // next is vpos once past the porch, otherwise vpos+1.
  always_comb begin
    hpos_nx   = (hpos == i_hm_raw - HW'(1)) ? '0 : hpos + HW'(1);
    vpos_inc  = (vpos == i_vm_raw - VW'(1)) ? '0 : vpos + VW'(1);
    vpos_nx   = (hpos == i_hm_porch - HW'(1)) ? vpos_inc : vpos;
    hsync     = (hpos >= i_hm_porch) && (hpos < i_hm_synch);
    vsync     = (vpos >= i_vm_porch) && (vpos < i_vm_synch);
    line_end  = (hpos == i_hm_width - HW'(1));
    frame_end = line_end && (vpos == i_vm_height - VW'(1));
    done_nx   = frame_done || frame_end;
    rd_nx     = (hpos_nx < i_hm_width) && (vpos_nx < i_vm_height) && done_nx;
    vline_nx  = (hpos >= i_hm_porch) ? vpos : vpos_inc;
    pre_ok    = frame_done && (vline_nx < i_vm_height);
    pre_window = pre_ok && (hpos >= i_hm_raw - HW'(10)) && (hpos <= i_hm_raw - HW'(3));
    pre_guard  = pre_ok && (hpos >= i_hm_raw - HW'(2));
  end

`ifdef HDMI_FRAMER_ISLAND_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LGUARD,
    S_DATA,
    S_TGUARD
  } isl_state_t;

  isl_state_t state, state_nx;
  logic [4:0] cnt, cnt_nx;

  // Island FSM state register; reset aborts any island in flight.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Island sequencing: commit on a valid word at width+3, then fixed-length phases.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 5'd1;
    unique case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if ((hpos == i_hm_width + HW'(3)) && i_pkt_valid) state_nx = S_PRE;
      end
      S_PRE: begin
        if (cnt == 5'd7) begin
          state_nx = S_LGUARD;
          cnt_nx   = '0;
        end
      end
      S_LGUARD: begin
        if (cnt == 5'd1) begin
          state_nx = S_DATA;
          cnt_nx   = '0;
        end
      end
      S_DATA: begin
        if (cnt == 5'd31) begin
          state_nx = S_TGUARD;
          cnt_nx   = '0;
        end
      end
      S_TGUARD: begin
        if (cnt == 5'd1) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign isl_pre   = (state == S_PRE);
  assign isl_guard = (state == S_LGUARD) || (state == S_TGUARD);
  assign isl_data  = (state == S_DATA);
  assign isl_first = (cnt == 5'd0);
  assign ready_nx  = (state_nx == S_DATA);
`else
  assign isl_pre   = 1'b0;
  assign isl_guard = 1'b0;
  assign isl_data  = 1'b0;
  assign isl_first = 1'b0;
  assign ready_nx  = 1'b0;
`endif

  // Period selection for the current raster position; island has priority
  // over the video preamble, though the two never coincide for legal modes.
  always_comb begin
    type_nx = T_CTL;
    ctl_nx  = '0;
    data_nx = {10'b0, vsync, hsync};
    pix_nx  = '0;
    uf_nx   = 1'b0;
    word    = i_pkt_valid ? i_pkt_word : '0;
    if (o_rd) begin
      type_nx = T_VIDEO;
      pix_nx  = {i_rgb_pix[3*BPC-1 -: 8], i_rgb_pix[2*BPC-1 -: 8], i_rgb_pix[BPC-1 -: 8]};
    end else if (isl_pre) begin
      ctl_nx = 4'h5;
    end else if (isl_guard) begin
      type_nx = T_GUARD;
    end else if (isl_data) begin
      type_nx = T_ISLAND;
      data_nx = {word[7:4], word[3:0], ~isl_first, word[8], vsync, hsync};
      uf_nx   = ~i_pkt_valid;
    end else if (pre_guard) begin
      type_nx = T_GUARD;
    end else if (pre_window) begin
      ctl_nx = 4'h1;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      hpos            <= '0;
      vpos            <= '0;
      frame_done      <= 1'b0;
      o_rd            <= 1'b0;
      o_pkt_ready     <= 1'b0;
      o_pkt_underflow <= 1'b0;
      o_newline       <= 1'b0;
      o_newframe      <= 1'b0;
      o_type          <= T_GUARD;
      o_ctl           <= '0;
      o_data          <= '0;
      o_red           <= '0;
      o_grn           <= '0;
      o_blu           <= '0;
    end else begin
      hpos            <= hpos_nx;
      vpos            <= vpos_nx;
      frame_done      <= done_nx;
      o_rd            <= rd_nx;
      o_pkt_ready     <= ready_nx;
      o_pkt_underflow <= uf_nx;
      o_newline       <= line_end;
      o_newframe      <= frame_end;
      o_type          <= type_nx;
      o_ctl           <= ctl_nx;
      o_data          <= data_nx;
      o_red           <= pix_nx[23:16];
      o_grn           <= pix_nx[15:8];
      o_blu           <= pix_nx[7:0];
    end
  end

endmodule

// File: tb/tb_hdmi_framer.sv
// tb_hdmi_framer: randomized stimulus against a position-arithmetic model.
// Follows HDMI_FRAMER_ISLAND_EN to choose the expected island behaviour.
module tb_hdmi_framer;

`ifdef HDMI_FRAMER_ISLAND_EN
  localparam bit ISLAND = 1'b1;
`else
  localparam bit ISLAND = 1'b0;
`endif
  localparam logic [1:0] GUARD = 2'b00, CTL = 2'b01, DISL = 2'b10, VIDEO = 2'b11;
  localparam int MAXK = 16384;

  typedef struct packed {
    logic        rd, rdy, nl, nf, uf;
    logic [1:0]  typ;
    logic [3:0]  ctl;
    logic [11:0] dat;
    logic [23:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rgb_pix = '0;
  logic [11:0] hm_width, hm_porch, hm_synch, hm_raw;
  logic [11:0] vm_height, vm_porch, vm_synch, vm_raw;
  logic        pkt_valid = 1'b0;
  logic [8:0]  pkt_word = '0;
  logic        pkt_ready, pkt_underflow, rd, newline, newframe;
  logic [1:0]  ptype;
  logic [3:0]  ctl;
  logic [11:0] data;
  logic [7:0]  red, grn, blu;

  int W, P, S, R, VH, VP, VS, VR;
  int k, checks, errors, rd_f2, nf_cnt, ready_cnt;
  bit valid_mode, found;
  logic [23:0] pix_h [MAXK];
  logic        val_h [MAXK];
  logic [8:0]  word_h [MAXK];

  hdmi_framer #(.HW(12), .VW(12), .BPC(8)) dut (
    .i_pixclk(clk), .i_reset(rst), .i_rgb_pix(rgb_pix),
    .i_hm_width(hm_width), .i_hm_porch(hm_porch), .i_hm_synch(hm_synch), .i_hm_raw(hm_raw),
    .i_vm_height(vm_height), .i_vm_porch(vm_porch), .i_vm_synch(vm_synch), .i_vm_raw(vm_raw),
    .i_pkt_valid(pkt_valid), .i_pkt_word(pkt_word),
    .o_pkt_ready(pkt_ready), .o_pkt_underflow(pkt_underflow),
    .o_rd(rd), .o_newline(newline), .o_newframe(newframe),
    .o_type(ptype), .o_ctl(ctl), .o_data(data),
    .o_red(red), .o_grn(grn), .o_blu(blu)
  );

  always #5 clk = ~clk;

  // Expected behaviour for raster index k (cycles since reset release).
  function automatic exp_t model(int kk);
    exp_t e;
    int h, L, v, d;
    bit hs, vs;
    logic [8:0] w;
    e = '0;
    h = kk % R;
    L = kk / R;
    v = ((kk + R - P) / R) % VR;
    hs = (h >= P) && (h < S);
    vs = (v >= VP) && (v < VS);
    e.rd = (h < W) && ((L % VR) < VH) && (L >= VR);
    e.nl = (h == W - 1);
    e.nf = e.nl && ((L % VR) == VH - 1);
    e.dat = {10'b0, vs, hs};
    e.typ = CTL;
    d = h - (W + 4);
    if (e.rd) begin
      e.typ = VIDEO;
      e.rgb = pix_h[kk];
    end else if (ISLAND && d >= 0 && d < 44 && val_h[L*R + W + 3]) begin
      if (d < 8) e.ctl = 4'h5;
      else if (d < 10 || d >= 42) e.typ = GUARD;
      else begin
        e.typ = DISL;
        e.rdy = 1'b1;
        w = val_h[kk] ? word_h[kk] : 9'd0;
        e.uf = !val_h[kk];
        e.dat = {w[7:4], w[3:0], (d != 10), w[8], vs, hs};
      end
    end else if (h >= R - 10 && ((L + 1) % VR) < VH && (L + 1) >= VR) begin
      if (h <= R - 3) e.ctl = 4'h1;
      else e.typ = GUARD;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s k=%0d observed %h expected %h", tag, k, obs, expv);
    end
  endtask

  // Drive cycle k inputs and check the outputs visible during cycle k.
  task automatic step_cycle();
    exp_t now_e, prev_e;
    pix_h[k]  = 24'($urandom);
    val_h[k]  = valid_mode ? ($urandom_range(0, 7) != 0) : 1'b0;
    word_h[k] = 9'($urandom);
    rgb_pix   = pix_h[k];
    pkt_valid = val_h[k];
    pkt_word  = word_h[k];
    now_e = model(k);
    if (k == 0) begin
      prev_e = '0;
      prev_e.typ = GUARD;
    end else begin
      prev_e = model(k - 1);
    end
    chk("rd", rd, now_e.rd);
    chk("pkt_ready", pkt_ready, now_e.rdy);
    chk("type", ptype, prev_e.typ);
    chk("ctl", ctl, prev_e.ctl);
    chk("data", data, prev_e.dat);
    chk("rgb", {red, grn, blu}, prev_e.rgb);
    chk("newline", newline, prev_e.nl);
    chk("newframe", newframe, prev_e.nf);
    chk("underflow", pkt_underflow, prev_e.uf);
    if (rd && k >= VR*R && k < 2*VR*R) rd_f2++;
    if (newframe) nf_cnt++;
    if (pkt_ready) ready_cnt++;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      step_cycle();
      k++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int w, input int p, input int s, input int r,
                          input int vh, input int vp, input int vs, input int vr);
    rst = 1'b1;
    W = w; P = p; S = s; R = r; VH = vh; VP = vp; VS = vs; VR = vr;
    hm_width = 12'(w); hm_porch = 12'(p); hm_synch = 12'(s); hm_raw = 12'(r);
    vm_height = 12'(vh); vm_porch = 12'(vp); vm_synch = 12'(vs); vm_raw = 12'(vr);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    int n0, exp_nf;
    checks = 0; errors = 0;

    // Small mode, no packets: raster period, read strobes, preamble.
    valid_mode = 1'b0;
    do_reset(16, 20, 24, 32, 17, 19, 21, 23);
    rd_f2 = 0; nf_cnt = 0; ready_cnt = 0;
    run(2300);
    chk("rd_count_frame2", rd_f2, 16*17);
    n0 = (VH - 1)*R + W - 1;
    exp_nf = (2300 - 2 - n0) / (R*VR) + 1;
    chk("newframe_count", nf_cnt, exp_nf);
    chk("ready_idle", ready_cnt, 0);

    // Wide mode with random packet traffic, including underflow gaps.
    valid_mode = 1'b1;
    do_reset(16, 20, 24, 80, 17, 19, 21, 23);
    ready_cnt = 0;
    run(3700);
    chk("ready_total_nonzero", (ready_cnt > 0), ISLAND);

    // Reset in the middle of an island data phase.
`ifdef HDMI_FRAMER_ISLAND_EN
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      step_cycle();
      if (model(k).rdy && (k % R) == W + 4 + 15) found = 1'b1;
      k++;
      if (!found) @(negedge clk);
    end
    chk("reset_trigger_found", found, 1);
`else
    run(777);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("rst_type", ptype, GUARD);
    chk("rst_ready", pkt_ready, 0);
    chk("rst_data", data, 0);
    chk("rst_ctl", ctl, 0);
    rst = 1'b0;
    k = 0;
    run(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
